carrier_phase_acc: RTL and testbench

- Phase-accumulator NCO that produces the 5-bit sample address for the 32-entry carrier sine table in the carrier generator.
- Tuning word and phase offset come from the modulation/control logic.
- A new tuning word/offset pair is taken in through a valid/ready handshake and applied at a phase wrap, so frequency and PSK phase changes are glitch-free.
- The block also emits a wrap pulse for downstream symbol timing and marks each valid address.

---
 rtl/carrier_gen_pkg.sv | 22 ++
 rtl/carrier_lfsr16.sv | 21 ++
 rtl/carrier_phase_acc.sv | 131 +++++++++++++
 tb/tb_carrier_phase_acc.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/carrier_gen_pkg.sv
// Shared constants for the carrier generator: accumulator defaults, reset
// tuning word, dither LFSR constants and the PSK phase offsets in table steps.
package carrier_gen_pkg;

    localparam int          ACC_W_DEF     = 32;
    localparam int          ADDR_W_DEF    = 5;
    localparam logic [31:0] FTW_RESET_DEF = 32'h0800_0000;

    // x^16 + x^14 + x^13 + x^11 + 1, taps on bits 15, 13, 12 and 10
    localparam logic [15:0] LFSR_TAPS     = 16'hB400;
    localparam logic [15:0] LFSR_SEED     = 16'hACE1;

    localparam logic [4:0]  POFF_0        = 5'd0;
    localparam logic [4:0]  POFF_90       = 5'd8;
    localparam logic [4:0]  POFF_180      = 5'd16;
    localparam logic [4:0]  POFF_270      = 5'd24;

    function automatic int min_int(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/carrier_lfsr16.sv
// 16-bit Fibonacci LFSR used as the address dither source; advances only
// when step is high.
module carrier_lfsr16
    import carrier_gen_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        step,
    output logic [15:0] q
);

    // Shift left, feeding the XOR of the tapped bits into bit 0
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= LFSR_SEED;
        end else if (step) begin
            q <= {q[14:0], ^(q & LFSR_TAPS)};
        end
    end

endmodule

// File: rtl/carrier_phase_acc.sv
// Phase-accumulator NCO producing the sine-table address for the carrier
// generator. Tuning word / phase offset updates arrive over a valid/ready
// handshake into shadow registers and are applied at a phase wrap (or
// immediately on phase_clr) so frequency and PSK changes are glitch-free.
//
// Handshake: an update transfers on any clock edge where upd_valid and
// upd_ready are both high; upd_ready is low for as long as a captured
// update has not yet been applied.
//
// Optional dither: define CARRIER_PHASE_DITHER_EN to add LFSR noise below
// the address LSB before truncation (address path only).
module carrier_phase_acc
    import carrier_gen_pkg::*;
#(
    parameter int               ACC_W       = ACC_W_DEF,
    parameter int               ADDR_W      = ADDR_W_DEF,
    parameter logic [ACC_W-1:0] FTW_RESET   = FTW_RESET_DEF,
    parameter bit               SYNC_UPDATE = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en,
    input  logic              phase_clr,
    input  logic [ACC_W-1:0]  ftw_in,
    input  logic [ADDR_W-1:0] poff_in,
    input  logic              upd_valid,
    output logic              upd_ready,
    output logic [ADDR_W-1:0] address,
    output logic              addr_valid,
    output logic              wrap,
    output logic              upd_applied
);

    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  ftw_cur;
    logic [ADDR_W-1:0] poff_cur;
    logic [ACC_W-1:0]  shadow_ftw;
    logic [ADDR_W-1:0] shadow_poff;
    logic              pending;

    logic [ACC_W:0]    sum;
    logic [ACC_W-1:0]  acc_n;
    logic              carry;
    logic [ADDR_W-1:0] addr_base;
    logic [ADDR_W-1:0] addr_next;
    logic              accept;
    logic              apply_en;

    assign sum       = {1'b0, acc} + {1'b0, ftw_cur};
    assign acc_n     = sum[ACC_W-1:0];
    assign carry     = sum[ACC_W];

`ifdef CARRIER_PHASE_DITHER_EN
    localparam int DITH_W = min_int(16, ACC_W - ADDR_W - 1);

    logic [15:0]      lfsr_q;
    logic [ACC_W-1:0] dith_sum;

    carrier_lfsr16 u_lfsr (
        .clk     (clk),
        .reset_n (reset_n),
        .step    (en & ~phase_clr),
        .q       (lfsr_q)
    );

    // Dither only perturbs the address; acc and carry stay exact
    assign dith_sum  = acc_n + ACC_W'(lfsr_q[DITH_W-1:0]);
    assign addr_base = dith_sum[ACC_W-1 -: ADDR_W];
`else
    assign addr_base = acc_n[ACC_W-1 -: ADDR_W];
`endif

    assign addr_next = addr_base + poff_cur;
    assign upd_ready = ~pending;
    assign accept    = upd_valid & ~pending;
    // A zero tuning word never wraps, so it must not wait for a carry
    assign apply_en  = pending & (carry | ~SYNC_UPDATE | (ftw_cur == '0));

    // Accumulator, active/shadow tuning registers and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc         <= '0;
            ftw_cur     <= FTW_RESET;
            poff_cur    <= '0;
            shadow_ftw  <= '0;
            shadow_poff <= '0;
            pending     <= 1'b0;
            address     <= '0;
            addr_valid  <= 1'b0;
            wrap        <= 1'b0;
            upd_applied <= 1'b0;
        end else begin
            addr_valid  <= 1'b0;
            wrap        <= 1'b0;
            upd_applied <= 1'b0;

            // accept requires !pending, so it never collides with an apply
            if (accept) begin
                shadow_ftw  <= ftw_in;
                shadow_poff <= poff_in;
                pending     <= 1'b1;
            end

            if (phase_clr) begin
                acc        <= '0;
                addr_valid <= 1'b1;
                if (pending) begin
                    ftw_cur     <= shadow_ftw;
                    poff_cur    <= shadow_poff;
                    pending     <= 1'b0;
                    upd_applied <= 1'b1;
                    address     <= shadow_poff;
                end else begin
                    address     <= poff_cur;
                end
            end else if (en) begin
                acc        <= acc_n;
                address    <= addr_next;
                wrap       <= carry;
                addr_valid <= 1'b1;
                if (apply_en) begin
                    ftw_cur     <= shadow_ftw;
                    poff_cur    <= shadow_poff;
                    pending     <= 1'b0;
                    upd_applied <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_carrier_phase_acc.sv
// Directed testbench for carrier_phase_acc (default build, SYNC_UPDATE = 1).
module tb_carrier_phase_acc;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        en;
    logic        phase_clr;
    logic [31:0] ftw_in;
    logic [4:0]  poff_in;
    logic        upd_valid;
    logic        upd_ready;
    logic [4:0]  address;
    logic        addr_valid;
    logic        wrap;
    logic        upd_applied;

    int n_tests = 0;
    int n_fail  = 0;

    carrier_phase_acc dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .en          (en),
        .phase_clr   (phase_clr),
        .ftw_in      (ftw_in),
        .poff_in     (poff_in),
        .upd_valid   (upd_valid),
        .upd_ready   (upd_ready),
        .address     (address),
        .addr_valid  (addr_valid),
        .wrap        (wrap),
        .upd_applied (upd_applied)
    );

    always #5 clk = ~clk;

    // Advance one edge; outputs are sampled and inputs driven 1 ns after it
    task automatic clk_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        en        = 1'b0;
        phase_clr = 1'b0;
        ftw_in    = '0;
        poff_in   = '0;
        upd_valid = 1'b0;
        clk_step();
        clk_step();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if ({address, addr_valid, wrap, upd_applied, upd_ready} !== {5'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_outputs: got addr=%0d av=%b wrap=%b ua=%b rdy=%b, want 0 0 0 0 1",
                     address, addr_valid, wrap, upd_applied, upd_ready);
        end
    endtask

    task automatic test_default_ftw();
        do_reset();
        en = 1'b1;
        for (int i = 1; i <= 33; i++) begin
            clk_step();
            n_tests++;
            if (address !== 5'(i) || wrap !== (i == 32) || addr_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL default_seq[%0d]: got addr=%0d wrap=%b av=%b, want addr=%0d wrap=%b av=1",
                         i, address, wrap, addr_valid, 5'(i), (i == 32));
            end
        end
    endtask

    task automatic test_freq_update();
        do_reset();
        en = 1'b1;
        for (int i = 1; i <= 10; i++) clk_step();
        n_tests++;
        if (address !== 5'd10) begin
            n_fail++;
            $display("FAIL freq_pre: got addr=%0d, want 10", address);
        end
        upd_valid = 1'b1;
        ftw_in    = 32'h1000_0000;
        poff_in   = 5'd0;
        clk_step();
        upd_valid = 1'b0;
        n_tests++;
        if (address !== 5'd11 || upd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL freq_capture: got addr=%0d rdy=%b, want 11 0", address, upd_ready);
        end
        for (int a = 12; a <= 31; a++) begin
            clk_step();
            n_tests++;
            if (address !== 5'(a) || upd_applied !== 1'b0 || upd_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL freq_hold[%0d]: got addr=%0d ua=%b rdy=%b, want %0d 0 0",
                         a, address, upd_applied, upd_ready, a);
            end
        end
        clk_step();
        n_tests++;
        if (address !== 5'd0 || wrap !== 1'b1 || upd_applied !== 1'b1 || upd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL freq_apply: got addr=%0d wrap=%b ua=%b rdy=%b, want 0 1 1 1",
                     address, wrap, upd_applied, upd_ready);
        end
        for (int k = 1; k <= 4; k++) begin
            clk_step();
            n_tests++;
            if (address !== 5'(2 * k) || upd_applied !== 1'b0) begin
                n_fail++;
                $display("FAIL freq_step2[%0d]: got addr=%0d ua=%b, want %0d 0",
                         k, address, upd_applied, 2 * k);
            end
        end
    endtask

    task automatic test_psk();
        do_reset();
        en        = 1'b1;
        upd_valid = 1'b1;
        ftw_in    = 32'h0800_0000;
        poff_in   = 5'd16;
        clk_step();
        upd_valid = 1'b0;
        for (int i = 2; i <= 32; i++) clk_step();
        n_tests++;
        if (address !== 5'd0 || wrap !== 1'b1 || upd_applied !== 1'b1) begin
            n_fail++;
            $display("FAIL psk_apply: got addr=%0d wrap=%b ua=%b, want 0 1 1", address, wrap, upd_applied);
        end
        for (int k = 1; k <= 32; k++) begin
            clk_step();
            n_tests++;
            if (address !== 5'((k + 16) % 32) || wrap !== (k == 32)) begin
                n_fail++;
                $display("FAIL psk_seq[%0d]: got addr=%0d wrap=%b, want %0d %b",
                         k, address, wrap, (k + 16) % 32, (k == 32));
            end
        end
    endtask

    task automatic test_zero_ftw();
        do_reset();
        en        = 1'b1;
        upd_valid = 1'b1;
        ftw_in    = 32'h0;
        poff_in   = 5'd0;
        clk_step();
        upd_valid = 1'b0;
        for (int i = 2; i <= 32; i++) clk_step();
        n_tests++;
        if (address !== 5'd0 || upd_applied !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_apply: got addr=%0d ua=%b, want 0 1", address, upd_applied);
        end
        for (int k = 0; k < 4; k++) begin
            clk_step();
            n_tests++;
            if (address !== 5'd0 || wrap !== 1'b0) begin
                n_fail++;
                $display("FAIL zero_hold[%0d]: got addr=%0d wrap=%b, want 0 0", k, address, wrap);
            end
        end
        upd_valid = 1'b1;
        ftw_in    = 32'h0800_0000;
        clk_step();
        upd_valid = 1'b0;
        n_tests++;
        if (upd_ready !== 1'b0 || upd_applied !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_capture: got rdy=%b ua=%b, want 0 0", upd_ready, upd_applied);
        end
        clk_step();
        n_tests++;
        if (upd_applied !== 1'b1 || address !== 5'd0 || upd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_reapply: got ua=%b addr=%0d rdy=%b, want 1 0 1", upd_applied, address, upd_ready);
        end
        clk_step();
        n_tests++;
        if (address !== 5'd1) begin
            n_fail++;
            $display("FAIL zero_resume: got addr=%0d, want 1", address);
        end
    endtask

    task automatic test_en_and_phase_clr();
        do_reset();
        en = 1'b1;
        for (int i = 1; i <= 7; i++) clk_step();
        en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            clk_step();
            n_tests++;
            if (address !== 5'd7 || addr_valid !== 1'b0 || wrap !== 1'b0) begin
                n_fail++;
                $display("FAIL en_hold[%0d]: got addr=%0d av=%b wrap=%b, want 7 0 0",
                         k, address, addr_valid, wrap);
            end
        end
        en = 1'b1;
        clk_step();
        n_tests++;
        if (address !== 5'd8 || addr_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL en_resume: got addr=%0d av=%b, want 8 1", address, addr_valid);
        end
        upd_valid = 1'b1;
        ftw_in    = 32'h0800_0000;
        poff_in   = 5'd8;
        clk_step();
        upd_valid = 1'b0;
        phase_clr = 1'b1;
        clk_step();
        n_tests++;
        if (address !== 5'd8 || upd_applied !== 1'b1 || wrap !== 1'b0 || addr_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL clr_apply: got addr=%0d ua=%b wrap=%b av=%b, want 8 1 0 1",
                     address, upd_applied, wrap, addr_valid);
        end
        // capture coinciding with phase_clr must not apply on that edge
        upd_valid = 1'b1;
        poff_in   = 5'd16;
        clk_step();
        upd_valid = 1'b0;
        n_tests++;
        if (address !== 5'd8 || upd_applied !== 1'b0 || upd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_capture_only: got addr=%0d ua=%b rdy=%b, want 8 0 0",
                     address, upd_applied, upd_ready);
        end
        clk_step();
        n_tests++;
        if (address !== 5'd16 || upd_applied !== 1'b1) begin
            n_fail++;
            $display("FAIL clr_second: got addr=%0d ua=%b, want 16 1", address, upd_applied);
        end
        phase_clr = 1'b0;
        clk_step();
        n_tests++;
        if (address !== 5'd17 || wrap !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_resume: got addr=%0d wrap=%b, want 17 0", address, wrap);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        en = 1'b1;
        for (int i = 1; i <= 5; i++) clk_step();
        upd_valid = 1'b1;
        ftw_in    = 32'h1000_0000;
        poff_in   = 5'd16;
        clk_step();
        upd_valid = 1'b0;
        n_tests++;
        if (address !== 5'd6 || upd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_pre: got addr=%0d rdy=%b, want 6 0", address, upd_ready);
        end
        reset_n = 1'b0;
        #1;
        n_tests++;
        if ({address, addr_valid, wrap, upd_applied, upd_ready} !== {5'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL rst_async: got addr=%0d av=%b wrap=%b ua=%b rdy=%b, want 0 0 0 0 1",
                     address, addr_valid, wrap, upd_applied, upd_ready);
        end
        clk_step();
        reset_n = 1'b1;
        for (int i = 1; i <= 33; i++) begin
            clk_step();
            n_tests++;
            if (address !== 5'(i) || upd_applied !== 1'b0 || upd_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL rst_after[%0d]: got addr=%0d ua=%b rdy=%b, want %0d 0 1",
                         i, address, upd_applied, upd_ready, 5'(i));
            end
        end
    endtask

    initial begin
        test_reset();
        test_default_ftw();
        test_freq_update();
        test_psk();
        test_zero_ftw();
        test_en_and_phase_clr();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
